sr_cmd_sequencer: RTL and testbench

SR_CMD_SEQUENCER -- requirements
Module: sr_cmd_sequencer

---
 rtl/sr_pkg.sv | 16 +
 rtl/sr_cmd_sequencer.sv | 119 +++++++++++
 tb/tb_sr_cmd_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR command sequencer:
// request opcode encoding and sequencer state enumeration.
package sr_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DRIVE  = 2'b01,
        ST_SETTLE = 2'b10
    } state_t;

endpackage

// File: rtl/sr_cmd_sequencer.sv
// Sequences set/clear/toggle commands onto a downstream asynchronous
// SR flip-flop and checks its fed-back q after a quiet settle gap.
module sr_cmd_sequencer
    import sr_pkg::*;
#(
    parameter int PULSE_LEN = 2,
    parameter int GAP       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       s,
    output logic       r,
    input  logic       fb_q,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       err_clr,
    output logic       shadow_q
);

    // Counters hold "cycles left minus one" so each phase ends at zero.
    localparam logic [3:0] DRIVE_LAST  = 4'(PULSE_LEN - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(GAP - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       tgt, tgt_n;
    logic       s_n, r_n, done_n, err_n, shadow_n;
    logic       sel;

    assign req_ready = (state == ST_IDLE);
    assign busy      = ~req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            tgt      <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            shadow_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            tgt      <= tgt_n;
            s        <= s_n;
            r        <= r_n;
            done     <= done_n;
            err      <= err_n;
            shadow_q <= shadow_n;
        end
    end

    always_comb begin
        sel = ~shadow_q;
        unique case (req_op)
            OP_CLR:  sel = 1'b0;
            OP_SET:  sel = 1'b1;
            default: sel = ~shadow_q;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        tgt_n    = tgt;
        s_n      = 1'b0;
        r_n      = 1'b0;
        done_n   = 1'b0;
        shadow_n = shadow_q;
        err_n    = err_clr ? 1'b0 : err;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_op == OP_NOP) begin
                        done_n = 1'b1;
                    end else begin
                        tgt_n   = sel;
                        s_n     = sel;
                        r_n     = ~sel;
                        cnt_n   = DRIVE_LAST;
                        state_n = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt == 4'd0) begin
                    cnt_n   = SETTLE_LAST;
                    state_n = ST_SETTLE;
                end else begin
                    s_n   = tgt;
                    r_n   = ~tgt;
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    // A fresh mismatch overrides a coincident err_clr.
                    if (fb_q != tgt)
                        err_n = 1'b1;
                    shadow_n = tgt;
                    done_n   = 1'b1;
                    state_n  = ST_IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed and randomized bench for sr_cmd_sequencer driving
// behavioural SR flip-flops on its s/r outputs.
module tb_sr_cmd_sequencer;
    import sr_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic [1:0] req_op = OP_NOP;
    logic err_clr = 1'b0;
    logic req_ready, s, r, busy, done, err, shadow_q;
    logic q = 1'b0;
    logic force_fb = 1'b0;
    logic fb_val = 1'b0;
    logic fb;

    logic v2 = 1'b0;
    logic [1:0] op2 = OP_NOP;
    logic rdy2, s2, r2, busy2, done2, err2, shadow2;
    logic q2 = 1'b0;

    int vecs = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge s or posedge r or posedge reset)
        if (reset) q <= 1'b0;
        else if (s) q <= 1'b1;
        else q <= 1'b0;

    always @(posedge s2 or posedge r2 or posedge reset)
        if (reset) q2 <= 1'b0;
        else if (s2) q2 <= 1'b1;
        else q2 <= 1'b0;

    assign fb = force_fb ? fb_val : q;

    sr_cmd_sequencer #(.PULSE_LEN(2), .GAP(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_op(req_op), .req_ready(req_ready), .s(s), .r(r),
        .fb_q(fb), .busy(busy), .done(done), .err(err),
        .err_clr(err_clr), .shadow_q(shadow_q)
    );

    sr_cmd_sequencer #(.PULSE_LEN(3), .GAP(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2),
        .req_op(op2), .req_ready(rdy2), .s(s2), .r(r2),
        .fb_q(q2), .busy(busy2), .done(done2), .err(err2),
        .err_clr(1'b0), .shadow_q(shadow2)
    );

    task automatic test_reset;
        reset = 1'b1;
        #3;
        vecs++;
        if ({s, r, done, busy, req_ready, err, shadow_q} !== 7'b0000100) begin
            miscompares++;
            $display("FAIL reset_out got=%b want=0000100",
                     {s, r, done, busy, req_ready, err, shadow_q});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vecs++;
        if ({s, r, done, busy, req_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL post_reset got=%b want=00001",
                     {s, r, done, busy, req_ready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_set;
        logic [3:0] want;
        req_valid = 1'b1; req_op = OP_SET;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = OP_NOP;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            want = {c <= 2, 1'b0, c == 4, c <= 3};
            vecs++;
            if ({s, r, done, busy} !== want) begin
                miscompares++;
                $display("FAIL set_c%0d srdb got=%b want=%b",
                         c, {s, r, done, busy}, want);
            end
            if (c == 4) begin
                vecs++;
                if ({shadow_q, fb, err} !== 3'b110) begin
                    miscompares++;
                    $display("FAIL set_done shadow/fb/err got=%b want=110",
                             {shadow_q, fb, err});
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_toggle_b2b;
        logic [3:0] want;
        req_valid = 1'b1; req_op = OP_TGL;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            want = {c == 5 || c == 6, c == 1 || c == 2,
                    c == 4 || c == 8, c != 4 && c != 8};
            vecs++;
            if ({s, r, done, busy} !== want) begin
                miscompares++;
                $display("FAIL tgl_c%0d srdb got=%b want=%b",
                         c, {s, r, done, busy}, want);
            end
            if (c == 4) begin
                vecs++;
                if ({shadow_q, fb} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL tgl_first shadow/fb got=%b want=00",
                             {shadow_q, fb});
                end
            end
            @(posedge clk); #1;
            if (c == 3) begin req_valid = 1'b1; req_op = OP_TGL; end
            if (c == 4) req_valid = 1'b0;
        end
        vecs++;
        if ({shadow_q, fb} !== 2'b11) begin
            miscompares++;
            $display("FAIL tgl_second shadow/fb got=%b want=11", {shadow_q, fb});
        end
    endtask

    task automatic test_busy_hold;
        logic [3:0] want;
        req_valid = 1'b1; req_op = OP_CLR;
        @(posedge clk); #1;
        req_op = OP_SET;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            want = {c == 5 || c == 6, c == 1 || c == 2,
                    c == 4 || c == 8, c != 4 && c != 8};
            vecs++;
            if ({s, r, done, busy} !== want) begin
                miscompares++;
                $display("FAIL hold_c%0d srdb got=%b want=%b",
                         c, {s, r, done, busy}, want);
            end
            if (c == 4) begin
                vecs++;
                if (shadow_q !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_clr shadow got=%b want=0", shadow_q);
                end
            end
            @(posedge clk); #1;
            if (c == 4) begin req_valid = 1'b0; req_op = OP_NOP; end
        end
        vecs++;
        if (shadow_q !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_set shadow got=%b want=1", shadow_q);
        end
    endtask

    task automatic test_nop;
        req_valid = 1'b1; req_op = OP_NOP;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if ({s, r, done, busy, req_ready, shadow_q} !== 6'b001011) begin
            miscompares++;
            $display("FAIL nop_c1 got=%b want=001011",
                     {s, r, done, busy, req_ready, shadow_q});
        end
        @(posedge clk); #1;
        @(negedge clk);
        vecs++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL nop_c2 done/busy got=%b want=00", {done, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_err;
        force_fb = 1'b1; fb_val = 1'b0;
        req_valid = 1'b1; req_op = OP_SET;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vecs++;
            if ({done, err} !== {c == 4, c == 4}) begin
                miscompares++;
                $display("FAIL err_c%0d done/err got=%b want=%b",
                         c, {done, err}, {c == 4, c == 4});
            end
            @(posedge clk); #1;
        end
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        vecs++;
        if ({err, shadow_q} !== 2'b11) begin
            miscompares++;
            $display("FAIL err_sticky err/shadow got=%b want=11", {err, shadow_q});
        end
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        vecs++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear got=%b want=0", err);
        end
        @(posedge clk); #1;
        err_clr = 1'b1;
        req_valid = 1'b1; req_op = OP_SET;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vecs++;
            if ({done, err} !== {c == 4, c == 4}) begin
                miscompares++;
                $display("FAIL errclr_c%0d done/err got=%b want=%b",
                         c, {done, err}, {c == 4, c == 4});
            end
            @(posedge clk); #1;
            if (c == 3) err_clr = 1'b0;
        end
        @(negedge clk);
        vecs++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL errclr_hold got=%b want=1", err);
        end
        @(posedge clk); #1;
        force_fb = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [3:0] want;
        req_valid = 1'b1; req_op = OP_CLR;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if ({s, r, busy} !== 3'b011) begin
            miscompares++;
            $display("FAIL rmid_drive s/r/busy got=%b want=011", {s, r, busy});
        end
        #2;
        reset = 1'b1;
        #1;
        vecs++;
        if ({s, r, done, busy, req_ready, err, shadow_q, fb} !== 8'b00001000) begin
            miscompares++;
            $display("FAIL rmid_abort got=%b want=00001000",
                     {s, r, done, busy, req_ready, err, shadow_q, fb});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vecs++;
            if ({done, busy, s, r} !== 4'b0000) begin
                miscompares++;
                $display("FAIL rmid_quiet%0d got=%b want=0000",
                         c, {done, busy, s, r});
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b1; req_op = OP_SET;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = OP_NOP;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            want = {c <= 2, 1'b0, c == 4, c <= 3};
            vecs++;
            if ({s, r, done, busy} !== want) begin
                miscompares++;
                $display("FAIL rmid_set_c%0d srdb got=%b want=%b",
                         c, {s, r, done, busy}, want);
            end
            @(posedge clk); #1;
        end
        vecs++;
        if ({shadow_q, fb, err} !== 3'b110) begin
            miscompares++;
            $display("FAIL rmid_after shadow/fb/err got=%b want=110",
                     {shadow_q, fb, err});
        end
    endtask

    task automatic test_random;
        int acc = 0;
        int dn = 0;
        for (int i = 0; i < 10010; i++) begin
            v2 = (i < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            op2 = 2'($urandom_range(0, 3));
            @(negedge clk);
            vecs++;
            if (s2 && r2) begin
                miscompares++;
                $display("FAIL rnd_sr_overlap cycle=%0d s=%b r=%b want not both 1",
                         i, s2, r2);
            end
            if (v2 && rdy2) acc++;
            if (done2) begin
                dn++;
                vecs++;
                if (shadow2 !== q2) begin
                    miscompares++;
                    $display("FAIL rnd_shadow cycle=%0d shadow=%b want fb=%b",
                             i, shadow2, q2);
                end
            end
            @(posedge clk); #1;
        end
        vecs++;
        if (dn !== acc || acc < 100) begin
            miscompares++;
            $display("FAIL rnd_count done=%0d want accepted=%0d (>=100)", dn, acc);
        end
        vecs++;
        if (err2 !== 1'b0 || busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_end err/busy got=%b%b want=00", err2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_toggle_b2b();
        test_busy_hold();
        test_nop();
        test_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
